// File: rtl/st2_pkg.sv
// Shared encodings for the stage-2 branch controller: branch condition codes,
// comparator result codes, controller state type and the taken rule.
package st2_pkg;

  localparam logic [1:0] COND_UNCOND = 2'b00;
  localparam logic [1:0] COND_BLT    = 2'b01;
  localparam logic [1:0] COND_BGT    = 2'b10;
  localparam logic [1:0] COND_BEQ    = 2'b11;

  localparam logic [1:0] CMP_NONE    = 2'b00;
  localparam logic [1:0] CMP_LESS    = 2'b01;
  localparam logic [1:0] CMP_GREATER = 2'b10;
  localparam logic [1:0] CMP_EQUAL   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_FLUSH = 2'b10
  } br_state_t;

  // Condition codes are chosen so a conditional branch is taken exactly when
  // the comparator reports the matching code; "no result" never satisfies one.
  function automatic logic br_is_taken(input logic [1:0] cond, input logic [1:0] cmp);
    return (cond == COND_UNCOND) || ((cmp != CMP_NONE) && (cmp == cond));
  endfunction

endpackage

// File: rtl/st2_branch_ctrl.sv
// Stage-2 branch controller: resolves branches when operands are ready,
// stalls IF/ID while waiting for forwarding, redirects the PC and squashes
// IF/ID for one cycle on a taken branch, and gives up after WAIT_MAX cycles.
module st2_branch_ctrl
  import st2_pkg::*;
#(
  parameter int WAIT_MAX = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_valid,
  input  logic [1:0]  br_cond,
  input  logic [15:0] br_target,
  input  logic [1:0]  cmp_result,
  input  logic        opnd_ready,
  input  logic        cnt_clr,
  output logic        stall_if_id,
  output logic        pc_load,
  output logic [15:0] pc_target,
  output logic        flush_if,
  output logic        timeout_err,
  output logic [7:0]  taken_cnt
);

  localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  br_state_t   state;
  logic [CW-1:0] wcnt;
  logic [1:0]  lat_cond;
  logic [15:0] lat_target;

  logic [1:0]  eval_cond;
  logic [15:0] eval_target;
  logic        eval_now;
  logic        eval_taken;
  logic        start_wait;

  // Pick the branch being resolved this cycle: live inputs in IDLE, latched copy in WAIT.
  always_comb begin
    eval_cond   = br_cond;
    eval_target = br_target;
    eval_now    = 1'b0;
    case (state)
      ST_IDLE: eval_now = br_valid & opnd_ready;
      ST_WAIT: begin
        eval_cond   = lat_cond;
        eval_target = lat_target;
        eval_now    = opnd_ready;
      end
      default: eval_now = 1'b0;
    endcase
    eval_taken = eval_now & br_is_taken(eval_cond, cmp_result);
    start_wait = (state == ST_IDLE) & br_valid & ~opnd_ready;
    stall_if_id = rst_n & (start_wait | ((state == ST_WAIT) & ~opnd_ready));
  end

  // Controller FSM with registered redirect, squash and timeout outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wcnt        <= '0;
      pc_load     <= 1'b0;
      flush_if    <= 1'b0;
      pc_target   <= 16'h0000;
      timeout_err <= 1'b0;
    end else begin
      pc_load     <= 1'b0;
      flush_if    <= 1'b0;
      timeout_err <= 1'b0;
      if (eval_taken) begin
        state     <= ST_FLUSH;
        pc_load   <= 1'b1;
        flush_if  <= 1'b1;
        pc_target <= eval_target;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_wait) begin
              state <= ST_WAIT;
              wcnt  <= '0;
            end
          end
          ST_WAIT: begin
            if (opnd_ready) begin
              state <= ST_IDLE;
            end else if (wcnt == CW'(WAIT_MAX - 1)) begin
              state       <= ST_IDLE;
              timeout_err <= 1'b1;
            end else begin
              wcnt <= wcnt + CW'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Hold the condition and target of a branch that has to wait for operands.
  always_ff @(posedge clk) begin
    if (start_wait) begin
      lat_cond   <= br_cond;
      lat_target <= br_target;
    end
  end

  // Saturating count of branches redirected; a clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt <= 8'd0;
    end else if (cnt_clr) begin
      taken_cnt <= 8'd0;
    end else if (eval_taken && (taken_cnt != 8'hFF)) begin
      taken_cnt <= taken_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_st2_branch_ctrl.sv
// Bench for st2_branch_ctrl: directed scenarios plus randomized traffic; a
// branch-level reference model predicts every cycle's outputs into a queue and
// an independent monitor pops and compares.
module tb_st2_branch_ctrl;

  localparam int WAIT_MAX = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        br_valid = 1'b0;
  logic [1:0]  br_cond = 2'b00;
  logic [15:0] br_target = 16'h0000;
  logic [1:0]  cmp_result = 2'b00;
  logic        opnd_ready = 1'b0;
  logic        cnt_clr = 1'b0;
  logic        stall_if_id;
  logic        pc_load;
  logic [15:0] pc_target;
  logic        flush_if;
  logic        timeout_err;
  logic [7:0]  taken_cnt;

  always #5 clk = ~clk;

  st2_branch_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_cond(br_cond),
    .br_target(br_target), .cmp_result(cmp_result), .opnd_ready(opnd_ready),
    .cnt_clr(cnt_clr), .stall_if_id(stall_if_id), .pc_load(pc_load),
    .pc_target(pc_target), .flush_if(flush_if), .timeout_err(timeout_err),
    .taken_cnt(taken_cnt)
  );

  typedef struct packed {
    logic        stall;
    logic        load;
    logic        flush;
    logic        tmo;
    logic [15:0] tgt;
    logic [7:0]  cnt;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: one outstanding branch, a pending redirect, a counter.
  bit          m_waiting;
  bit          m_redirect;
  bit          m_tmo;
  logic [1:0]  m_cond;
  logic [15:0] m_ptgt;
  logic [15:0] m_tgt;
  int          m_waited;
  int          m_cnt;

  function automatic bit rule_taken(input logic [1:0] c, input logic [1:0] r);
    if (c == 2'b00) return 1'b1;
    if (r == 2'b00) return 1'b0;
    return (r == c);
  endfunction

  task automatic model_clear();
    m_waiting = 0; m_redirect = 0; m_tmo = 0; m_cond = 2'b00;
    m_ptgt = 16'h0; m_tgt = 16'h0; m_waited = 0; m_cnt = 0;
  endtask

  initial model_clear();

  always @(negedge clk) begin
    obs_t e;
    bit   nxt_redirect, nxt_tmo, redirect_now;
    if (!rst_n) begin
      model_clear();
      e = '0;
    end else begin
      e.stall = m_waiting ? !opnd_ready : (!m_redirect && br_valid && !opnd_ready);
      e.load  = m_redirect;
      e.flush = m_redirect;
      e.tmo   = m_tmo;
      e.tgt   = m_tgt;
      e.cnt   = 8'(m_cnt);
      nxt_redirect = 0;
      nxt_tmo      = 0;
      redirect_now = 0;
      if (m_redirect) begin
        // squash cycle: the instruction presented now is discarded
      end else if (m_waiting) begin
        if (opnd_ready) begin
          m_waiting = 0;
          if (rule_taken(m_cond, cmp_result)) begin
            redirect_now = 1; m_tgt = m_ptgt;
          end
        end else begin
          m_waited++;
          if (m_waited == WAIT_MAX) begin
            m_waiting = 0; nxt_tmo = 1;
          end
        end
      end else if (br_valid) begin
        if (opnd_ready) begin
          if (rule_taken(br_cond, cmp_result)) begin
            redirect_now = 1; m_tgt = br_target;
          end
        end else begin
          m_waiting = 1; m_cond = br_cond; m_ptgt = br_target; m_waited = 0;
        end
      end
      if (redirect_now) begin
        nxt_redirect = 1;
        if (m_cnt < 255) m_cnt++;
      end
      if (cnt_clr) m_cnt = 0;
      m_redirect = nxt_redirect;
      m_tmo      = nxt_tmo;
    end
    exp_q.push_back(e);
  end

  // Monitor: compares DUT outputs against the oldest prediction each cycle.
  initial begin
    obs_t a, e;
    forever begin
      @(negedge clk);
      #1;
      a = {stall_if_id, pc_load, flush_if, timeout_err, pc_target, taken_cnt};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard @%0t: no prediction available", $time);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          n_bad++;
          $display("FAIL outputs @%0t: got stall=%b load=%b flush=%b tmo=%b tgt=%h cnt=%0d, expected stall=%b load=%b flush=%b tmo=%b tgt=%h cnt=%0d",
                   $time, a.stall, a.load, a.flush, a.tmo, a.tgt, a.cnt,
                   e.stall, e.load, e.flush, e.tmo, e.tgt, e.cnt);
        end
      end
    end
  end

  task automatic cyc(input bit v, input logic [1:0] c, input logic [15:0] t,
                     input logic [1:0] r, input bit rdy, input bit clr);
    br_valid = v; br_cond = c; br_target = t; cmp_result = r;
    opnd_ready = rdy; cnt_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 2'b00, 16'h0, 2'b00, 1, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Taken BEQ with operands ready
    cyc(1, 2'b11, 16'h0040, 2'b11, 1, 0);
    cyc(1, 2'b00, 16'hDEAD, 2'b00, 1, 0);
    idle(2);
    // Not-taken BLT
    cyc(1, 2'b01, 16'h0BAD, 2'b10, 1, 0);
    idle(2);
    // BGT waits three cycles; target inputs change meanwhile
    cyc(1, 2'b10, 16'h1234, 2'b00, 0, 0);
    cyc(1, 2'b10, 16'hFFFF, 2'b10, 0, 0);
    cyc(0, 2'b11, 16'h5555, 2'b00, 0, 0);
    cyc(1, 2'b00, 16'hAAAA, 2'b10, 1, 0);
    idle(3);
    // Operand wait limit exceeded
    cyc(1, 2'b10, 16'h0777, 2'b00, 0, 0);
    for (int i = 0; i < 9; i++) cyc(1'($urandom), 2'($urandom), 16'($urandom), 2'($urandom), 0, 0);
    idle(3);
    // Drive the taken counter into saturation, with traffic during squash cycles
    for (int i = 0; i < 262; i++) begin
      cyc(1, 2'b00, 16'($urandom), 2'($urandom), 1, 0);
      cyc(1'($urandom), 2'($urandom), 16'($urandom), 2'($urandom), 1'($urandom), 0);
    end
    cyc(1, 2'b00, 16'h0100, 2'b00, 1, 1);
    idle(2);
    cyc(1, 2'b11, 16'h0200, 2'b11, 1, 0);
    idle(1);
    cyc(0, 2'b00, 16'h0, 2'b00, 1, 1);
    idle(1);
    // Reset in the middle of WAIT
    cyc(1, 2'b01, 16'h2222, 2'b00, 0, 0);
    cyc(0, 2'b00, 16'h0, 2'b00, 0, 0);
    rst_n = 1'b0;
    cyc(1, 2'b01, 16'h3333, 2'b01, 1, 0);
    cyc(1, 2'b01, 16'h3333, 2'b00, 0, 0);
    rst_n = 1'b1;
    idle(3);
    // Reset in the middle of FLUSH
    cyc(1, 2'b00, 16'h4444, 2'b00, 1, 0);
    rst_n = 1'b0;
    cyc(0, 2'b00, 16'h0, 2'b00, 1, 0);
    rst_n = 1'b1;
    idle(3);

    // Randomized traffic: ready mostly high, then mostly low
    for (int i = 0; i < 3000; i++) begin
      bit rdy;
      rdy = (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      rst_n = ($urandom_range(0, 499) != 0);
      cyc($urandom_range(0, 2) != 0, 2'($urandom), 16'($urandom), 2'($urandom),
          rdy, $urandom_range(0, 199) == 0);
    end
    rst_n = 1'b1;
    idle(4);
    @(negedge clk);
    #2;
    if (exp_q.size() > 1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d predictions left, expected at most 1", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
